// File: rtl/axi_wr_burst_ctlr.sv
// AXI4 write master with burst support: commands become AW bursts, the write-data
// stream is framed into W bursts by a length FIFO, and in-order B responses become completions.
module axi_wr_burst_ctlr #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int AXI_ID    = 0,
    parameter int MAX_BEATS = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [8:0]          cmd_len,
    output logic                cmd_err,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                cpl_valid,
    output logic [1:0]          cpl_resp,
    output logic                cpl_err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [ID_W-1:0]     awid,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awlock,
    output logic [3:0]          awqos,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [0:0] {AW_IDLE = 1'b0, AW_BUSY = 1'b1} aw_state_e;

    aw_state_e         aw_state_q, aw_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]        len_mem_q [MAX_OUTST];
    logic [8:0]        len_mem_d [MAX_OUTST];
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              bready_q, bready_d;
    logic              cmd_err_q, cmd_err_d;
    logic              cpl_valid_q, cpl_valid_d;
    logic [1:0]        cpl_resp_q, cpl_resp_d;
    logic              cpl_err_q, cpl_err_d;

    logic              cmd_accept_s, legal_s, push_s, pop_s;
    logic              fifo_nonempty_s, w_hs_s, w_last_s, b_hs_s;
    logic [8:0]        head_len_s;
    logic [19:0]       span_s;
    logic              bid_unused_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Only one ID is ever issued, so responses arrive in order and bid carries no information.
    assign bid_unused_s = ^bid;

    assign cmd_ready    = (aw_state_q == AW_IDLE) && (inflight_q < CNT_W'(MAX_OUTST));
    assign cmd_accept_s = cmd_valid && cmd_ready;
    assign span_s       = {8'd0, cmd_addr[11:0]} + ({11'd0, cmd_len} << SIZE);
    assign legal_s      = (cmd_len != 9'd0) && (cmd_len <= 9'(MAX_BEATS))
                       && (cmd_addr[SIZE-1:0] == {SIZE{1'b0}}) && (span_s <= 20'd4096);
    assign push_s       = cmd_accept_s && legal_s;

    assign fifo_nonempty_s = (fifo_cnt_q != {CNT_W{1'b0}});
    assign head_len_s      = len_mem_q[rd_ptr_q];
    assign w_last_s        = fifo_nonempty_s && ({1'b0, beat_cnt_q} == (head_len_s - 9'd1));
    assign w_hs_s          = wd_valid && wready && fifo_nonempty_s;
    assign pop_s           = w_hs_s && w_last_s;
    assign b_hs_s          = bvalid && bready_q;

    assign awvalid   = (aw_state_q == AW_BUSY);
    assign awaddr    = awaddr_q;
    assign awlen     = awlen_q;
    assign awsize    = 3'(SIZE);
    assign awburst   = 2'b01;
    assign awid      = ID_W'(AXI_ID);
    assign awcache   = 4'b0000;
    assign awprot    = 3'b010;
    assign awlock    = 1'b0;
    assign awqos     = 4'b0000;
    assign wvalid    = wd_valid && fifo_nonempty_s;
    assign wd_ready  = wready && fifo_nonempty_s;
    assign wdata     = wd_data;
    assign wstrb     = wd_strb;
    assign wlast     = w_last_s;
    assign bready    = bready_q;
    assign cmd_err   = cmd_err_q;
    assign cpl_valid = cpl_valid_q;
    assign cpl_resp  = cpl_resp_q;
    assign cpl_err   = cpl_err_q;

    // AW channel FSM: load on legal accept, hold until awready.
    always_comb begin
        aw_state_d = aw_state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        case (aw_state_q)
            AW_IDLE: begin
                if (push_s) begin
                    aw_state_d = AW_BUSY;
                    awaddr_d   = cmd_addr;
                    awlen_d    = 8'(cmd_len - 9'd1);
                end else begin
                    aw_state_d = AW_IDLE;
                end
            end
            AW_BUSY: begin
                if (awready) begin
                    aw_state_d = AW_IDLE;
                end else begin
                    aw_state_d = AW_BUSY;
                end
            end
            default: aw_state_d = AW_IDLE;
        endcase
    end

    // Outstanding-command count, B acceptance and completion reporting.
    always_comb begin
        cmd_err_d   = cmd_accept_s && !legal_s;
        cpl_valid_d = b_hs_s;
        case ({push_s, b_hs_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        // bready follows the next inflight value so it never lags a final B.
        bready_d = (inflight_d != {CNT_W{1'b0}});
        if (b_hs_s) begin
            cpl_resp_d = bresp;
            cpl_err_d  = (bresp != 2'b00);
        end else begin
            cpl_resp_d = cpl_resp_q;
            cpl_err_d  = cpl_err_q;
        end
    end

    // Length FIFO and beat counter that frame the W stream into bursts.
    always_comb begin
        len_mem_d = len_mem_q;
        if (push_s) begin
            len_mem_d[wr_ptr_q] = cmd_len;
            wr_ptr_d            = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = next_ptr(rd_ptr_q);
            beat_cnt_d = 8'd0;
        end else if (w_hs_s) begin
            rd_ptr_d   = rd_ptr_q;
            beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            beat_cnt_d = beat_cnt_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_state_q  <= AW_IDLE;
            awaddr_q    <= {ADDR_W{1'b0}};
            awlen_q     <= 8'd0;
            inflight_q  <= {CNT_W{1'b0}};
            fifo_cnt_q  <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            beat_cnt_q  <= 8'd0;
            bready_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_resp_q  <= 2'b00;
            cpl_err_q   <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                len_mem_q[i] <= 9'd0;
            end
        end else begin
            aw_state_q  <= aw_state_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            bready_q    <= bready_d;
            cmd_err_q   <= cmd_err_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_resp_q  <= cpl_resp_d;
            cpl_err_q   <= cpl_err_d;
            len_mem_q   <= len_mem_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_ctlr.sv
// Bench for axi_wr_burst_ctlr: queue-based reference model checked every cycle,
// a legality vector table, directed corner sequences and a randomized traffic phase.
module tb_axi_wr_burst_ctlr;

    localparam int AW_P = 64, DW = 128, IDW = 4, MAXB = 16, MAXO = 4;
    localparam int BYTES = DW / 8;

    logic clk, rst_n;
    logic cmd_valid, cmd_ready, cmd_err;
    logic [AW_P-1:0] cmd_addr;
    logic [8:0] cmd_len;
    logic wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic [DW/8-1:0] wd_strb;
    logic cpl_valid, cpl_err;
    logic [1:0] cpl_resp;
    logic [AW_P-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst;
    logic [IDW-1:0] awid, bid;
    logic awvalid, awready, awlock;
    logic [3:0] awcache, awqos;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic wlast, wvalid, wready;
    logic [1:0] bresp;
    logic bvalid, bready;

    axi_wr_burst_ctlr #(.ADDR_W(AW_P), .DATA_W(DW), .ID_W(IDW), .AXI_ID(0),
                        .MAX_BEATS(MAXB), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_err(cpl_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready), .awcache(awcache), .awprot(awprot),
        .awlock(awlock), .awqos(awqos), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] wd_of(input int s);
        logic [31:0] v;
        v = 32'(s);
        return {v * 32'h9E37_79B9, ~v, v ^ 32'hA5A5_A5A5, v};
    endfunction

    function automatic bit is_legal(input logic [63:0] a, input int l);
        return (l >= 1) && (l <= MAXB) && ((a % BYTES) == 0) && ((a % 4096) + l * BYTES <= 4096);
    endfunction

    // reference model state
    typedef struct {logic [63:0] addr; int len;} aw_t;
    typedef struct {logic [127:0] d; bit last;} wbeat_t;
    aw_t aw_q[$];
    int wlen_q[$];
    wbeat_t w_log[$];
    int inflight_m, beat_m, aw_done_n, w_done_n, b_sent_n, legal_n, dut_cpl_n, w_total;
    bit err_pend, cpl_pend, armed;
    logic [1:0] cpl_resp_m;

    // stimulus controls: 0 low, 1 high, 2 random, 3 toggle
    int aw_mode, w_mode, wd_mode, b_mode, resp_fix, b_allow;
    bit b_force;

    always @(negedge clk) begin : mon
        bit ne, er, wl, acc, lg, whs;
        ne = (wlen_q.size() != 0);
        er = (aw_q.size() == 0) && (inflight_m < MAXO);
        wl = ne ? (beat_m == wlen_q[0] - 1) : 1'b0;
        if (armed) begin
            chk("cmd_ready", cmd_ready, er);
            chk("awvalid", awvalid, aw_q.size() != 0);
            if (aw_q.size() != 0) begin
                chk("awaddr", awaddr, aw_q[0].addr);
                chk("awlen", awlen, aw_q[0].len - 1);
            end
            chk("wvalid", wvalid, wd_valid && ne);
            chk("wd_ready", wd_ready, wready && ne);
            chk("wlast", wlast, wl);
            chk("wdata", wdata, wd_data);
            chk("wstrb", wstrb, wd_strb);
            chk("bready", bready, inflight_m != 0);
            chk("cmd_err", cmd_err, err_pend);
            chk("cpl_valid", cpl_valid, cpl_pend);
            if (cpl_pend) begin
                chk("cpl_resp", cpl_resp, cpl_resp_m);
                chk("cpl_err", cpl_err, cpl_resp_m != 2'b00);
            end
            if (cpl_valid === 1'b1) dut_cpl_n++;
        end
        if (!rst_n) begin
            aw_q.delete(); wlen_q.delete();
            inflight_m = 0; beat_m = 0; aw_done_n = 0; w_done_n = 0; b_sent_n = 0;
            legal_n = 0; dut_cpl_n = 0; err_pend = 0; cpl_pend = 0; armed = 1;
        end else if (armed) begin
            acc = cmd_valid && er;
            lg = is_legal(cmd_addr, int'(cmd_len));
            whs = wd_valid && wready && ne;
            err_pend = acc && !lg;
            cpl_pend = 1'b0;
            if (bvalid && inflight_m != 0) begin
                inflight_m--; cpl_pend = 1'b1; cpl_resp_m = bresp; b_sent_n++;
            end
            if (aw_q.size() != 0 && awready) begin
                void'(aw_q.pop_front()); aw_done_n++;
            end
            if (whs) begin
                w_log.push_back('{wdata, wl});
                w_total++; beat_m++;
                if (wl) begin
                    void'(wlen_q.pop_front()); beat_m = 0; w_done_n++;
                end
            end
            if (acc && lg) begin
                aw_q.push_back('{cmd_addr, int'(cmd_len)});
                wlen_q.push_back(int'(cmd_len));
                inflight_m++; legal_n++;
            end
        end
    end

    function automatic logic drive_rdy(input int mode, input logic cur);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'($urandom_range(0, 1));
            default: return ~cur;
        endcase
    endfunction

    // AXI slave: AW/W ready patterns and in-order B once both AW and W of a burst are done
    initial begin : slave
        int last_bs;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0; last_bs = -1;
        forever begin
            @(posedge clk); #1;
            awready = drive_rdy(aw_mode, awready);
            wready = drive_rdy(w_mode, wready);
            if (!rst_n) begin
                bvalid = 0; last_bs = -1;
            end else if (b_force) begin
                bvalid = 1; bresp = 2'b00; last_bs = -1;
            end else if (!(bvalid && b_sent_n == last_bs)) begin
                last_bs = b_sent_n;
                bvalid = (aw_done_n > b_sent_n) && (w_done_n > b_sent_n) && (b_sent_n < b_allow)
                         && (b_mode == 1 || $urandom_range(0, 1) == 1);
                bresp = (resp_fix < 0) ? 2'($urandom_range(0, 3)) : 2'(resp_fix);
            end
        end
    end

    // write-data source: beat payload is a function of its global sequence number
    initial begin : wsrc
        int last_wt;
        wd_valid = 0; last_wt = 0; wd_data = wd_of(0); wd_strb = '0;
        forever begin
            @(posedge clk); #1;
            if (!(wd_valid && w_total == last_wt))
                wd_valid = (wd_mode == 1) ? 1'b1 : (wd_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            last_wt = w_total;
            wd_data = wd_of(w_total);
            wd_strb = 16'(w_total * 7 + 3);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input int l);
        bit acc;
        acc = 0;
        cmd_valid = 1; cmd_addr = a; cmd_len = 9'(l);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); acc = cmd_ready;
            step();
            if (acc) break;
        end
        cmd_valid = 0;
        if (!acc) chk("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 5000; i++) begin
            idle = (inflight_m == 0) && (aw_q.size() == 0) && (wlen_q.size() == 0)
                   && !cpl_pend && !err_pend;
            if (idle) break;
            step();
        end
        if (!idle) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_cpl(output logic [1:0] r, output logic e);
        bit got;
        got = 0; r = 'x; e = 'x;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cpl_valid === 1'b1) begin got = 1; r = cpl_resp; e = cpl_err; end
            step();
            if (got) break;
        end
        if (!got) chk("cpl_timeout", 1'b0, 1'b1);
    endtask

    typedef struct {logic [63:0] addr; int len; bit err;} vec_t;
    vec_t vecs[8];

    initial begin : stim
        logic [1:0] r;
        logic e;
        int s0, c0, l;
        logic [63:0] a;
        vecs[0] = '{64'h1000, 0, 1'b1};
        vecs[1] = '{64'h1000, 17, 1'b1};
        vecs[2] = '{64'h0FF0, 2, 1'b1};
        vecs[3] = '{64'h1004, 1, 1'b1};
        vecs[4] = '{64'h1F10, 16, 1'b1};
        vecs[5] = '{64'h0FF0, 1, 1'b0};
        vecs[6] = '{64'h1F00, 16, 1'b0};
        vecs[7] = '{64'h1000, 16, 1'b0};

        armed = 0; rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        aw_mode = 1; w_mode = 1; wd_mode = 1; b_mode = 1; resp_fix = 0;
        b_allow = 32'h4000_0000; b_force = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_awvalid", awvalid, 1'b0); chk("rst_awaddr", awaddr, 64'h0);
        chk("rst_awlen", awlen, 8'h0); chk("rst_bready", bready, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0); chk("rst_cpl_valid", cpl_valid, 1'b0);
        chk("rst_cpl_resp", cpl_resp, 2'b00); chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_wd_ready", wd_ready, 1'b0); chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("awsize", awsize, 3'd4); chk("awburst", awburst, 2'b01); chk("awid", awid, 4'd0);
        chk("awcache", awcache, 4'd0); chk("awprot", awprot, 3'b010);
        chk("awlock", awlock, 1'b0); chk("awqos", awqos, 4'd0);
        step(); rst_n = 1; step();

        // single beat
        w_log.delete();
        send_cmd(64'h1000, 1);
        @(negedge clk);
        chk("t1_awvalid", awvalid, 1'b1); chk("t1_awaddr", awaddr, 64'h1000);
        chk("t1_awlen", awlen, 8'd0);
        wait_cpl(r, e);
        chk("t1_cpl_resp", r, 2'b00); chk("t1_cpl_err", e, 1'b0);
        chk("t1_beats", w_log.size(), 1); chk("t1_wlast", w_log[0].last, 1'b1);
        wait_idle();

        // 16-beat burst with wready toggling
        w_mode = 3; w_log.delete(); s0 = w_total;
        send_cmd(64'h2000, 16);
        @(negedge clk);
        chk("t2_awlen", awlen, 8'd15);
        wait_cpl(r, e);
        wait_idle();
        chk("t2_beats", w_log.size(), 16);
        for (int i = 0; i < 16 && i < w_log.size(); i++) begin
            chk("t2_data", w_log[i].d, wd_of(s0 + i));
            chk("t2_last", w_log[i].last, i == 15);
        end
        w_mode = 1;

        // outstanding limit with B withheld, then one SLVERR
        b_allow = b_sent_n; resp_fix = 2;
        for (int k = 0; k < 4; k++) send_cmd(64'h3000 + 64'(k * 256), 1);
        cmd_valid = 1; cmd_addr = 64'h3400; cmd_len = 9'd1;
        repeat (10) step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t3_full_ready", cmd_ready, 1'b0); step();
        end
        b_allow = b_sent_n + 1;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (cpl_valid === 1'b1) begin
                    got = 1;
                    chk("t3_cpl_resp", cpl_resp, 2'b10); chk("t3_cpl_err", cpl_err, 1'b1);
                    chk("t3_ready_after_b", cmd_ready, 1'b1);
                end
                step();
                if (got) break;
            end
            if (!got) chk("t3_cpl_timeout", 1'b0, 1'b1);
        end
        cmd_valid = 0;
        @(negedge clk);
        chk("t3_5th_awvalid", awvalid, 1'b1); chk("t3_5th_awaddr", awaddr, 64'h3400);
        step();
        b_allow = 32'h4000_0000; resp_fix = 0;
        wait_idle();

        // legality table
        for (int i = 0; i < 8; i++) begin
            send_cmd(vecs[i].addr, vecs[i].len);
            @(negedge clk);
            chk("tbl_cmd_err", cmd_err, vecs[i].err);
            chk("tbl_awvalid", awvalid, !vecs[i].err);
            chk("tbl_bready", bready, !vecs[i].err);
            wait_idle();
        end

        // stray B while nothing is in flight
        c0 = dut_cpl_n; b_force = 1;
        repeat (3) step();
        b_force = 0; step(); step();
        chk("stray_b_ignored", dut_cpl_n - c0, 0);

        // AW stalled while W completes
        aw_mode = 0; w_log.delete(); c0 = dut_cpl_n;
        send_cmd(64'h5000, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_awvalid", awvalid, 1'b1); chk("t5_awaddr", awaddr, 64'h5000);
            chk("t5_awlen", awlen, 8'd3);
            step();
        end
        chk("t5_w_first", w_log.size(), 4);
        chk("t5_no_cpl_yet", dut_cpl_n - c0, 0);
        aw_mode = 1;
        wait_cpl(r, e);
        chk("t5_cpl_resp", r, 2'b00);
        wait_idle();

        // reset after beat 5 of 8
        w_log.delete();
        send_cmd(64'h6000, 8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); step();
            if (w_log.size() >= 5) break;
        end
        chk("t6_beats_before_rst", w_log.size(), 5);
        rst_n = 0; step();
        @(negedge clk);
        chk("t6_awvalid", awvalid, 1'b0); chk("t6_wvalid", wvalid, 1'b0);
        chk("t6_wlast", wlast, 1'b0); chk("t6_bready", bready, 1'b0);
        chk("t6_cpl_valid", cpl_valid, 1'b0); chk("t6_awaddr", awaddr, 64'h0);
        step(); rst_n = 1; step();
        send_cmd(64'h7000, 2);
        wait_cpl(r, e);
        chk("t6_new_cpl_resp", r, 2'b00);
        wait_idle();

        // randomized traffic
        aw_mode = 2; w_mode = 2; wd_mode = 2; b_mode = 2; resp_fix = -1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 3) != 0) begin
                l = $urandom_range(1, MAXB);
                a = {$urandom, $urandom} & ~64'hFFF;
                a = a + 64'($urandom_range(0, 256 - l) * BYTES);
            end else begin
                l = $urandom_range(0, 20);
                a = 64'($urandom_range(0, 65535));
            end
            send_cmd(a, l);
        end
        wait_idle();
        chk("rand_cpl_total", dut_cpl_n, legal_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_ctlr.md
Name: axi_wr_burst_ctlr

Overview:
Parametrised AXI4 write master that replaces the single-beat write controller with burst support and multiple outstanding transactions. It accepts a command (address and beat count) plus a separate write-data stream, then issues AW and W independently. B responses are tracked in order and each one is reported on a completion port. It sits between the DMA engine and the AXI-MM master port of the PCIe bridge.

Parameters:
ADDR_W, 64, address width
DATA_W, 128, data width; power of 2, 32..1024
ID_W, 4, AXI ID width
AXI_ID, 0, constant awid value
MAX_BEATS, 16, maximum beats per burst (1..256)
MAX_OUTST, 4, maximum commands in flight (accepted, B not yet received); power of 2

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  ADDR_W  burst start address, byte address
cmd_len  in  9  beat count, 1..MAX_BEATS
cmd_err  out  1  one-cycle pulse: accepted command was rejected as illegal
wd_valid  in  1  write-data beat valid
wd_ready  out  1  write-data beat accepted
wd_data  in  DATA_W  beat data
wd_strb  in  DATA_W/8  beat byte strobes
cpl_valid  out  1  one-cycle pulse per B response
cpl_resp  out  2  bresp of the completed burst
cpl_err  out  1  cpl_resp != OKAY
awaddr/awlen/awsize/awburst/awid/awvalid/awready  AXI AW channel (ADDR_W/8/3/2/ID_W/1/1)
wdata/wstrb/wlast/wvalid/wready  AXI W channel (DATA_W/DATA_W/8/1/1/1)
bid/bresp/bvalid/bready  AXI B channel (ID_W/2/1/1)
awcache/awprot/awlock/awqos  out  4/3/1/4  tie-offs: 0, 3'b010, 0, 0

Behaviour:
- Reset: awvalid=0, awaddr=0, awlen=0, bready=0, cmd_err=0, cpl_valid=0, cpl_resp=0, inflight=0, length FIFO empty, beat counter=0. wvalid and wd_ready are 0 because the FIFO is empty. Reset mid-burst abandons all state; no recovery of partial bursts.
- Constants: awsize=log2(DATA_W/8), awburst=INCR (2'b01), awid=AXI_ID.
- cmd_ready = !awvalid && (inflight < MAX_OUTST). Combinational; must not depend on cmd_valid.
- Legality check at accept. A command is illegal if any of the following holds:
  - cmd_len==0 or cmd_len>MAX_BEATS;
  - addr not aligned to DATA_W/8;
  - addr[11:0] + cmd_len*(DATA_W/8) > 4096 (crosses a 4KB boundary).
- Illegal accept: cmd_err=1 on the next cycle, no AW, no FIFO push, inflight unchanged. The command's W data is not consumed.
- Legal accept: on the next cycle awvalid=1, awaddr=cmd_addr, awlen=cmd_len-1. cmd_len is pushed into the length FIFO (depth MAX_OUTST) and inflight increments.
- AW: awvalid/awaddr/awlen held stable until awready; awvalid clears the cycle after the handshake. Back-to-back commands therefore give at most one AW every 2 cycles.
- W path (combinational pass-through):
  - wvalid = wd_valid && fifo_nonempty; wd_ready = wready && fifo_nonempty; wdata/wstrb = wd_data/wd_strb.
  - wlast = fifo_nonempty && (beat_cnt == head_len-1).
  - On each W handshake beat_cnt increments. On the last beat beat_cnt returns to 0 and the FIFO pops.
  - W may lead AW (AXI-legal). Zero-bubble between bursts.
- B: bready = (inflight != 0), registered. On bvalid&&bready, cpl_valid=1 with cpl_resp=bresp on the next cycle, and inflight decrements. bid is ignored (single ID, responses in order).
- Simultaneous legal accept and B handshake in one cycle: inflight unchanged.
- inflight never exceeds MAX_OUTST; the FIFO cannot overflow because pushes are bounded by inflight.
- bvalid while inflight==0 is ignored because bready=0.

Test Plan:
- Single legal cmd (addr 0x1000, len 1), awready/wready high, B OKAY: awlen=0, one W beat with wlast=1, cpl_valid=1 with cpl_resp=0 and cpl_err=0.
- Cmd len 16 at 0x2000 with wready toggling every other cycle: exactly 16 W handshakes, wlast only on the 16th, data order preserved, awlen=15.
- Five cmds with B withheld (MAX_OUTST=4): cmd_ready drops after the 4th accept. One B (SLVERR) → cpl_err=1, cpl_resp=2, and the 5th cmd is accepted the next cycle.
- Illegal cmds (len 0; len 17; addr 0x0FF0 len 2; addr 0x1004): each gives a cmd_err pulse, no awvalid, inflight=0.
- AW stall: awready low for 10 cycles while W completes: awaddr/awlen stay stable, W finishes first, completion follows the B handshake.
- Reset asserted mid-burst (beat 5 of 8): all outputs return to reset values next cycle; a new cmd afterwards completes normally.
